// File: rtl/fetch_pkg.sv
// Shared types and default constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2,
    VALID = 2'd3
  } fetch_state_e;

  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_PC_STEP  = 1;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word request to imem, valid/ready hand-off
// to decode, branch redirect that squashes stale in-flight or held words.
//
// state | meaning
// IDLE  | single post-reset cycle, launches the first request
// FETCH | request to pc outstanding, data will be kept
// DROP  | request outstanding to a stale address, data will be discarded
// VALID | instruction held for decode, no request outstanding
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEF_PC_STEP)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic               change_pc,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_inc;
  logic              take;
  logic              req_nxt, valid_nxt, capture;
  logic [ADDR_W-1:0] addr_nxt;

  assign take   = ex_valid & change_pc;
  assign pc_inc = pc + PC_STEP;

  always_comb begin
    state_nxt = state;
    req_nxt   = imem_req;
    addr_nxt  = imem_addr;
    valid_nxt = instr_valid;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = FETCH;
        req_nxt   = 1'b1;
        addr_nxt  = pc;
      end
      FETCH: begin
        if (imem_ack && !take) begin
          capture   = 1'b1;
          valid_nxt = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = VALID;
        end else if (imem_ack && take) begin
          req_nxt  = 1'b1;
          addr_nxt = branch_target;
        end else if (take) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // the address may only move once the stale request has been acked
        if (imem_ack) begin
          state_nxt = FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = take ? branch_target : pc;
        end
      end
      VALID: begin
        if (take) begin
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          addr_nxt  = branch_target;
          state_nxt = FETCH;
        end else if (instr_ready) begin
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          addr_nxt  = pc_inc;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nxt;
      imem_req    <= req_nxt;
      imem_addr   <= addr_nxt;
      instr_valid <= valid_nxt;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

  // branch beats increment beats hold; take is meaningless before the first fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (take && state != IDLE) begin
      pc <= branch_target;
    end else if (state == VALID && instr_ready) begin
      pc <= pc_inc;
    end
  end

endmodule
